conv_window_loader: RTL and testbench
=====================================

# conv_window_loader

Upstream feeder for the MAC datapath. Fetches a 4x4 filter and a stream of 4x4 image windows (stride 1, valid padding) from a byte-wide synchronous-read memory, packs each into 128-bit words, and hands them to the MAC controller over a valid/ready handshake. Horizontal steps reuse three window columns and fetch only the new column; a new row reloads all 16 bytes.

## Interface
- IMG_W, 16, image width in bytes (>= 4)
- IMG_H, 16, image height in bytes (>= 4)
- FILT_BASE, 256, memory address of filter byte 0
- ADDR_W, 9, memory address width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last window transfers
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address; image pixel (r,c) at r*IMG_W+c
- mem_data  in  8  read data, valid the cycle after mem_rd
- win  out  128  image window; pixel (i,j) at bits [8(4i+j)+7 : 8(4i+j)]
- filt  out  128  filter, same packing; byte k from FILT_BASE+k
- win_row  out  4  window top-left row
- win_col  out  4  window top-left column
- win_valid  out  1  win/filt/win_row/win_col are presentable
- win_ready  in  1  consumer accepts

## Operation
- States: IDLE, LOAD_FILT, LOAD_WIN, LOAD_COL, PRESENT, DONE.
- IDLE: start=1 -> LOAD_FILT, row=col=0.
- LOAD_FILT: 16 reads FILT_BASE..FILT_BASE+15, one per cycle, then one drain cycle -> LOAD_WIN.
- LOAD_WIN: 16 reads of rows row..row+3, cols col..col+3, row-major, plus drain -> PRESENT.
- PRESENT: win_valid=1. On win_valid&win_ready: if row=IMG_H-4 and col=IMG_W-4 -> DONE; else if col=IMG_W-4 -> row+1, col=0, LOAD_WIN; else col+1, LOAD_COL.
- LOAD_COL: each window byte (i,j) <= (i,j+1) for j<3; column 3 filled by 4 reads of (row+i, col+3), i=0..3, plus drain -> PRESENT.
- DONE: done=1 for one cycle -> IDLE.
- Addresses built from a running row-base register (add IMG_W per row); no multiplier.
- Frame yields (IMG_W-3)*(IMG_H-3) windows; 169 at defaults.
- start while busy ignored. win_ready outside PRESENT ignored.
- filt constant from end of LOAD_FILT until next start's LOAD_FILT.
- Reset: state IDLE; win, filt, win_row, win_col, mem_addr = 0; mem_rd, win_valid, busy, done = 0. Reset mid-frame aborts immediately; no partial transfer.

## Timing
- Start sampled at edge E0: LOAD_FILT reads after E0..E15, captures E2..E17; LOAD_WIN from E17, captures E19..E34; win_valid high after E34 (34 cycles start->first window).
- After a handshake: next window valid 5 cycles later (same row) or 17 cycles later (new row).
- win, win_row, win_col held stable while win_valid=1 and win_ready=0.
- win_valid drops the cycle after the accepting edge.
- done high the cycle after the last handshake; busy low the cycle after done.
- mem_rd never asserted in PRESENT, DONE, IDLE.

## Structure
- Shared package: state encoding, WIN_DIM=4, PIX_W=8, WIN_BITS=128, byte-index helper 4i+j.
- One sub-module: window_reg4x4 (16 byte registers, load-byte-at-index, shift-columns-left, clear); instantiated for win; filt uses load-byte only.

## Test plan
- Reset: rst=0 mid-run -> all outputs 0, state IDLE, next cycle busy=0.
- mem[a]=a&0xFF, mem[256+k]=k, start -> win_valid after 34 cycles, win byte(i,j)=16i+j, filt byte k=k, row=col=0.
- win_ready=0 for 10 cycles in PRESENT -> win, win_row, win_col unchanged, no mem_rd.
- Accept (0,0) -> 5 cycles later win byte(i,j)=16i+j+1, col=1; accept (0,12) -> 17 cycles later row=1, col=0, byte(i,j)=16(i+1)+j.
- win_ready tied 1 -> exactly 169 transfers, last row=12 col=12 byte(3,3)=255, single done pulse, start during run ignored.
- rst low during LOAD_WIN of row 5, then restart -> first window again byte(i,j)=16i+j at (0,0).

Source files
------------

// File: rtl/conv_window_loader_pkg.sv
// Shared types and helpers for the convolution window loader.
// Holds the FSM encoding, window geometry and the byte-index packing rule.
package conv_window_loader_pkg;

    localparam int WIN_DIM   = 4;
    localparam int PIX_W     = 8;
    localparam int WIN_BYTES = WIN_DIM * WIN_DIM;
    localparam int WIN_BITS  = WIN_BYTES * PIX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_FILT,
        ST_LOAD_WIN,
        ST_LOAD_COL,
        ST_PRESENT,
        ST_DONE
    } state_t;

    // Byte (i,j) of a 4x4 window lives at index 4i+j.
    function automatic logic [3:0] byte_idx(input logic [1:0] i, input logic [1:0] j);
        return {i, j};
    endfunction

    // Memory reads issued by each load state; zero for non-load states.
    function automatic logic [4:0] reads_for(input state_t s);
        case (s)
            ST_LOAD_FILT: return 5'd16;
            ST_LOAD_WIN:  return 5'd16;
            ST_LOAD_COL:  return 5'd4;
            default:      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/conv_window_loader_if.sv
// Memory read port and window handshake bundle between the loader and its
// neighbours: master = loader, slave = memory + MAC controller side.
interface conv_window_loader_if #(
    parameter int ADDR_W = 9
) ();
    logic                                     mem_rd;
    logic [ADDR_W-1:0]                        mem_addr;
    logic [7:0]                               mem_data;
    logic [conv_window_loader_pkg::WIN_BITS-1:0] win;
    logic [conv_window_loader_pkg::WIN_BITS-1:0] filt;
    logic [3:0]                               win_row;
    logic [3:0]                               win_col;
    logic                                     win_valid;
    logic                                     win_ready;

    modport master (
        output mem_rd, mem_addr, win, filt, win_row, win_col, win_valid,
        input  mem_data, win_ready
    );

    modport slave (
        input  mem_rd, mem_addr, win, filt, win_row, win_col, win_valid,
        output mem_data, win_ready
    );
endinterface

// File: rtl/window_reg4x4.sv
// 4x4 byte register file: clear, load one byte by index, shift columns left.
// Latency: 1 cycle per operation; no backpressure (pure storage).
// Backpressure: none; caller sequences clr/shift/ld.
module window_reg4x4
    import conv_window_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 shift,
    input  logic                 ld,
    input  logic [3:0]           ld_idx,
    input  logic [PIX_W-1:0]     ld_dat,
    output logic [WIN_BITS-1:0]  q
);

    logic [PIX_W-1:0] pix [WIN_BYTES];

    // A load in the same cycle as a shift wins for its byte, so a column
    // refill may overlap the shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WIN_BYTES; k++) pix[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < WIN_BYTES; k++) pix[k] <= '0;
        end else begin
            if (shift) begin
                for (int i = 0; i < WIN_DIM; i++) begin
                    for (int j = 0; j < WIN_DIM - 1; j++) begin
                        pix[byte_idx(2'(i), 2'(j))] <= pix[byte_idx(2'(i), 2'(j + 1))];
                    end
                end
            end
            if (ld) pix[ld_idx] <= ld_dat;
        end
    end

    always_comb begin
        q = '0;
        for (int k = 0; k < WIN_BYTES; k++) q[k*PIX_W +: PIX_W] = pix[k];
    end

endmodule

// File: rtl/conv_window_loader.sv
// Fetches a 4x4 filter then every 4x4 stride-1 window of the image, reusing 3 columns per step.
// Latency: 34 cycles start->first window, 5 per column step, 17 per new row.
// Backpressure: window held in PRESENT until win_ready; no reads issued while waiting.
module conv_window_loader
    import conv_window_loader_pkg::*;
#(
    parameter int IMG_W     = 16,
    parameter int IMG_H     = 16,
    parameter int FILT_BASE = 256,
    parameter int ADDR_W    = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    conv_window_loader_if.master      bus
);

    localparam logic [3:0]        LAST_COL  = 4'(IMG_W - WIN_DIM);
    localparam logic [3:0]        LAST_ROW  = 4'(IMG_H - WIN_DIM);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] FILT_ADDR = ADDR_W'(FILT_BASE);

    state_t            state, state_nxt;
    logic [3:0]        row, col, row_nxt, col_nxt;
    logic [ADDR_W-1:0] row_base, row_base_nxt;
    logic [ADDR_W-1:0] line_addr, line_base, rd_addr;
    logic [4:0]        cnt, cnt_base;
    logic [3:0]        rd_idx;
    logic              issue, entering, step_line, load_done, hs;
    logic              win_clr, win_shift;

    // Read tag pipeline: s1 travels with mem_rd, s2 lines up with mem_data.
    logic [3:0]        s1_idx, s2_idx;
    logic              s1_filt, s2_filt, s2_vld;

    assign hs        = (state == ST_PRESENT) && bus.win_ready;
    assign load_done = (cnt == reads_for(state)) && !bus.mem_rd;

    always_comb begin
        state_nxt    = state;
        row_nxt      = row;
        col_nxt      = col;
        row_base_nxt = row_base;
        win_clr      = 1'b0;
        win_shift    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_LOAD_FILT;
                    row_nxt      = '0;
                    col_nxt      = '0;
                    row_base_nxt = '0;
                    win_clr      = 1'b1;
                end
            end
            ST_LOAD_FILT: if (load_done) state_nxt = ST_LOAD_WIN;
            ST_LOAD_WIN,
            ST_LOAD_COL:  if (load_done) state_nxt = ST_PRESENT;
            ST_PRESENT: begin
                if (hs) begin
                    if (row == LAST_ROW && col == LAST_COL) begin
                        state_nxt = ST_DONE;
                    end else if (col == LAST_COL) begin
                        state_nxt    = ST_LOAD_WIN;
                        row_nxt      = row + 4'd1;
                        col_nxt      = '0;
                        row_base_nxt = row_base + ROW_STEP;
                    end else begin
                        state_nxt = ST_LOAD_COL;
                        col_nxt   = col + 4'd1;
                        win_shift = 1'b1;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The first read of a load phase goes out on the same edge that enters it.
    always_comb begin
        entering  = (state_nxt != state);
        cnt_base  = entering ? 5'd0 : cnt;
        line_base = entering ? row_base_nxt : line_addr;
        issue     = (cnt_base < reads_for(state_nxt));
        rd_addr   = FILT_ADDR + ADDR_W'(cnt_base);
        rd_idx    = cnt_base[3:0];
        step_line = 1'b0;
        case (state_nxt)
            ST_LOAD_WIN: begin
                rd_addr   = line_base + ADDR_W'(col_nxt) + ADDR_W'(cnt_base[1:0]);
                rd_idx    = byte_idx(cnt_base[3:2], cnt_base[1:0]);
                step_line = (cnt_base[1:0] == 2'd3);
            end
            ST_LOAD_COL: begin
                rd_addr   = line_base + ADDR_W'(col_nxt) + ADDR_W'(3);
                rd_idx    = byte_idx(cnt_base[1:0], 2'd3);
                step_line = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            row_base  <= '0;
            line_addr <= '0;
            cnt       <= '0;
        end else begin
            state    <= state_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            row_base <= row_base_nxt;
            cnt      <= cnt_base + 5'(issue);
            if (issue) line_addr <= step_line ? line_base + ROW_STEP : line_base;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_rd   <= 1'b0;
            bus.mem_addr <= '0;
            s1_idx       <= '0;
            s1_filt      <= 1'b0;
            s2_vld       <= 1'b0;
            s2_idx       <= '0;
            s2_filt      <= 1'b0;
        end else begin
            bus.mem_rd <= issue;
            if (issue) begin
                bus.mem_addr <= rd_addr;
                s1_idx       <= rd_idx;
                s1_filt      <= (state_nxt == ST_LOAD_FILT);
            end
            s2_vld  <= bus.mem_rd;
            s2_idx  <= s1_idx;
            s2_filt <= s1_filt;
        end
    end

    window_reg4x4 u_win (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (win_clr),
        .shift  (win_shift),
        .ld     (s2_vld && !s2_filt),
        .ld_idx (s2_idx),
        .ld_dat (bus.mem_data),
        .q      (bus.win)
    );

    window_reg4x4 u_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .shift  (1'b0),
        .ld     (s2_vld && s2_filt),
        .ld_idx (s2_idx),
        .ld_dat (bus.mem_data),
        .q      (bus.filt)
    );

    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);
    assign bus.win_valid = (state == ST_PRESENT);
    assign bus.win_row   = row;
    assign bus.win_col   = col;

endmodule

// File: tb/tb_conv_window_loader.sv
// Bench for conv_window_loader: byte-addressed memory model, window scoreboard,
// handshake-gap monitor and directed latency / hold / reset sequences.
module tb_conv_window_loader;
    import conv_window_loader_pkg::*;

    localparam int IMG_W  = 16;
    localparam int IMG_H  = 16;
    localparam int ADDR_W = 9;
    localparam int NWIN   = (IMG_W - 3) * (IMG_H - 3);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    conv_window_loader_if #(.ADDR_W(ADDR_W)) bus ();

    conv_window_loader #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .FILT_BASE(256), .ADDR_W(ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [512];
    always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] win;
        logic [3:0]   row;
        logic [3:0]   col;
    } exp_t;

    typedef struct {
        int         i;
        int         j;
        logic [7:0] exp_win;
        logic [7:0] exp_filt;
    } vec_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0;
    int   xfer_cnt = 0, done_cnt = 0, rd_in_present = 0;
    logic [127:0] last_win;
    logic [3:0]   last_row, last_col, prev_col;
    bit   gap_en = 0;
    int   prev_hs = -1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] model_win(input int r, input int c);
        logic [127:0] w = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                w[8*(4*i+j) +: 8] = 8'((r + i) * IMG_W + c + j);
        return w;
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int r = 0; r <= IMG_H - 4; r++)
            for (int c = 0; c <= IMG_W - 4; c++) begin
                e.win = model_win(r, c);
                e.row = 4'(r);
                e.col = 4'(c);
                sb.push_back(e);
            end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.win_valid && bus.mem_rd) rd_in_present++;
                if (done) done_cnt++;
                if (bus.win_valid && bus.win_ready) begin
                    check("sb_nonempty", 128'(sb.size() > 0), 128'(1));
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("win_data", bus.win, e.win);
                        check("win_pos", {bus.win_row, bus.win_col}, {e.row, e.col});
                    end
                    if (gap_en && prev_hs >= 0)
                        check("hs_gap", 128'(cyc - prev_hs), (prev_col == 4'(IMG_W - 4)) ? 128'(18) : 128'(6));
                    prev_hs  = cyc;
                    prev_col = bus.win_col;
                    last_win = bus.win;
                    last_row = bus.win_row;
                    last_col = bus.win_col;
                    xfer_cnt++;
                end
            end
        end
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            @(posedge clk); #1;
            n++;
            if (bus.win_valid) return;
        end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (n < bound && !done) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", 128'(done), 128'(1));
        @(posedge clk); #1;
        check("busy_after_done", 128'(busy), 128'(0));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_valid_rd"}, 128'({bus.win_valid, bus.mem_rd}), 128'(0));
        check({tag, "_win"}, bus.win, 128'(0));
        check({tag, "_filt"}, bus.filt, 128'(0));
        check({tag, "_addr_pos"}, 128'({bus.mem_addr, bus.win_row, bus.win_col}), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs [6];
        int lat, x0, d0, n, rd_seen, changed;
        logic [127:0] w0;

        vecs[0] = '{0, 0, 8'd0,  8'd0};
        vecs[1] = '{0, 3, 8'd3,  8'd3};
        vecs[2] = '{1, 0, 8'd16, 8'd4};
        vecs[3] = '{2, 1, 8'd33, 8'd9};
        vecs[4] = '{3, 0, 8'd48, 8'd12};
        vecs[5] = '{3, 3, 8'd51, 8'd15};

        for (int a = 0; a < 512; a++) mem[a] = 8'(a);
        bus.win_ready = 1'b0;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame 1: first-window latency, contents, hold under backpressure, column step.
        x0 = xfer_cnt; d0 = done_cnt;
        push_frame();
        pulse_start();
        wait_valid(60, lat);
        check("first_latency", 128'(lat), 128'(34));
        for (int v = 0; v < 6; v++) begin
            check($sformatf("first_win_%0d_%0d", vecs[v].i, vecs[v].j),
                  128'(bus.win[8*(4*vecs[v].i+vecs[v].j) +: 8]), 128'(vecs[v].exp_win));
            check($sformatf("filt_%0d_%0d", vecs[v].i, vecs[v].j),
                  128'(bus.filt[8*(4*vecs[v].i+vecs[v].j) +: 8]), 128'(vecs[v].exp_filt));
        end
        check("first_pos", 128'({bus.win_row, bus.win_col}), 128'(0));

        w0 = bus.win; rd_seen = 0; changed = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.mem_rd) rd_seen++;
            if (bus.win !== w0 || bus.win_row !== 4'd0 || bus.win_col !== 4'd0 || !bus.win_valid)
                changed++;
        end
        check("hold_stable", 128'(changed), 128'(0));
        check("hold_no_rd", 128'(rd_seen), 128'(0));

        bus.win_ready = 1'b1;
        @(posedge clk); #1;
        bus.win_ready = 1'b0;
        check("valid_drop", 128'(bus.win_valid), 128'(0));
        wait_valid(60, lat);
        check("col_step_latency", 128'(lat), 128'(5));
        check("col_step_win", bus.win, model_win(0, 1));
        check("col_step_pos", 128'({bus.win_row, bus.win_col}), 128'({4'd0, 4'd1}));

        bus.win_ready = 1'b1;
        wait_done(5000);
        check("f1_xfers", 128'(xfer_cnt - x0), 128'(NWIN));
        check("f1_sb_empty", 128'(sb.size()), 128'(0));
        check("f1_done_pulses", 128'(done_cnt - d0), 128'(1));

        // Frame 2: ready tied high, gap checks, start while busy ignored.
        x0 = xfer_cnt; d0 = done_cnt;
        gap_en = 1; prev_hs = -1;
        push_frame();
        pulse_start();
        repeat (200) @(posedge clk);
        #1;
        pulse_start();
        wait_done(5000);
        repeat (5) @(posedge clk);
        #1;
        check("f2_xfers", 128'(xfer_cnt - x0), 128'(NWIN));
        check("f2_sb_empty", 128'(sb.size()), 128'(0));
        check("f2_done_pulses", 128'(done_cnt - d0), 128'(1));
        check("f2_last_pos", 128'({last_row, last_col}), 128'({4'd12, 4'd12}));
        check("f2_last_byte33", 128'(last_win[127:120]), 128'(255));
        check("f2_idle_after", 128'(busy), 128'(0));

        // Frame 3: reset during the row-5 window load, then a clean restart.
        prev_hs = -1;
        push_frame();
        pulse_start();
        n = 0;
        while (n < 3000 && !(busy && bus.win_row == 4'd5 && !bus.win_valid)) begin
            @(posedge clk); #1;
            n++;
        end
        check("row5_load_reached", 128'(n < 3000), 128'(1));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        prev_hs = -1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("busy_after_rst", 128'(busy), 128'(0));

        x0 = xfer_cnt; d0 = done_cnt;
        push_frame();
        pulse_start();
        wait_valid(60, lat);
        check("restart_latency", 128'(lat), 128'(34));
        check("restart_win", bus.win, model_win(0, 0));
        check("restart_pos", 128'({bus.win_row, bus.win_col}), 128'(0));
        wait_done(5000);
        check("f3_xfers", 128'(xfer_cnt - x0), 128'(NWIN));
        check("f3_sb_empty", 128'(sb.size()), 128'(0));
        check("f3_done_pulses", 128'(done_cnt - d0), 128'(1));

        check("no_rd_in_present", 128'(rd_in_present), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
